// File: rtl/board_display_scanner_pkg.sv
// Shared types and constants for the board display scanner.
// Board word layout, tile indexing and 7-segment glyph patterns.
package board_display_scanner_pkg;

  localparam int TILE_W    = 4;
  localparam int NUM_TILES = 16;
  localparam int DIGITS    = 8;
  localparam int BOARD_W   = TILE_W * NUM_TILES;

  typedef logic [BOARD_W-1:0] board_t;
  typedef logic [TILE_W-1:0]  tile_t;
  typedef logic [3:0]         tile_idx_t;
  typedef logic [2:0]         digit_t;
  typedef logic [6:0]         seg7_t;

  typedef enum logic {
    PAGE0 = 1'b0,
    PAGE1 = 1'b1
  } page_e;

  // gfedcba, active-high
  localparam seg7_t SEG_BLANK = 7'h00;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_A     = 7'h77;
  localparam seg7_t SEG_B     = 7'h7C;
  localparam seg7_t SEG_C     = 7'h39;
  localparam seg7_t SEG_D     = 7'h5E;
  localparam seg7_t SEG_E     = 7'h79;
  localparam seg7_t SEG_F     = 7'h71;

  // Tile i = row*4+col lives in bits [4i+3:4i], row 0 on top.
  function automatic tile_t board_tile(board_t b, tile_idx_t idx);
    return b[idx*TILE_W +: TILE_W];
  endfunction

  // Page 0 shows tiles 0-7, page 1 shows tiles 8-15.
  function automatic tile_idx_t page_tile(page_e pg, digit_t d);
    return {pg == PAGE1, d};
  endfunction

  // Decimal point marks the end of each board row.
  function automatic logic row_end(digit_t d);
    return d[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/board_display_scanner_if.sv
// Board-state input and multiplexed display output bundle.
// slave: scanner side; master: board source / display side.
interface board_display_scanner_if;
  import board_display_scanner_pkg::*;

  board_t     total_current_state;
  logic       freeze;
  logic [7:0] seg_data;
  logic [7:0] seg_com;
  logic       page;
  logic       frame_latched;

  modport slave (
    input  total_current_state,
    input  freeze,
    output seg_data,
    output seg_com,
    output page,
    output frame_latched
  );

  modport master (
    output total_current_state,
    output freeze,
    input  seg_data,
    input  seg_com,
    input  page,
    input  frame_latched
  );

endinterface

// File: rtl/board_display_scanner_tile_seg_encoder.sv
// Tile exponent to 7-segment glyph lookup (combinational).
// tile_i: 4-bit exponent; seg_o: gfedcba, zero tile is blank.
module tile_seg_encoder
  import board_display_scanner_pkg::*;
(
  input  tile_t tile_i,
  output seg7_t seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (tile_i)
      4'h0: seg_o = SEG_BLANK;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/board_display_scanner.sv
// Board display scanner: 8-digit muxed 7-seg, two pages of 8 tiles.
// clk/rst (async active-low); bus.slave carries board in, display out.
module board_display_scanner
  import board_display_scanner_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000,
  parameter int PAGE_SCANS  = 400
) (
  input  logic clk,
  input  logic rst,
  board_display_scanner_if.slave bus
);

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam int SW = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(PAGE_SCANS - 1);

  logic [TW-1:0] tick_q, tick_d;
  digit_t        digit_q, digit_d;
  logic [SW-1:0] scan_q, scan_d;
  board_t        snap_q, snap_d;
  page_e         page_q;
  logic          init_q;
  logic          frame_q;
  logic [7:0]    seg_com_q;
  logic [7:0]    seg_data_q;

  logic  step;
  logic  wrap;
  logic  bound;
  logic  load;
  tile_t tile;
  seg7_t glyph;

  assign step  = tick_q == TICK_LAST;
  assign wrap  = step && (digit_q == 3'd7);
  assign bound = wrap && (scan_q == SCAN_LAST);
  // init_q forces one load on the first clock out of reset
  assign load  = wrap || init_q;

  always_comb begin
    tick_d  = step ? '0 : tick_q + 1'b1;
    digit_d = step ? digit_q + 3'd1 : digit_q;
    scan_d  = scan_q;
    if (wrap) begin
      scan_d = bound ? '0 : scan_q + 1'b1;
    end
    snap_d = load ? bus.total_current_state : snap_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q  <= '0;
      digit_q <= '0;
      scan_q  <= '0;
      snap_q  <= '0;
      init_q  <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      digit_q <= digit_d;
      scan_q  <= scan_d;
      snap_q  <= snap_d;
      init_q  <= 1'b0;
      frame_q <= load && (bus.total_current_state != snap_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      page_q <= PAGE0;
    end else if (bound && !bus.freeze) begin
      unique case (page_q)
        PAGE0:   page_q <= PAGE1;
        PAGE1:   page_q <= PAGE0;
        default: page_q <= PAGE0;
      endcase
    end
  end

  // Mux reads the snapshot only; the live word never reaches a digit.
  assign tile = board_tile(snap_q, page_tile(page_q, digit_q));

  tile_seg_encoder u_enc (
    .tile_i (tile),
    .seg_o  (glyph)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_com_q  <= 8'hFF;
      seg_data_q <= 8'h00;
    end else begin
      seg_com_q  <= ~(8'b1 << digit_q);
      seg_data_q <= {row_end(digit_q), glyph};
    end
  end

  assign bus.seg_com       = seg_com_q;
  assign bus.seg_data      = seg_data_q;
  assign bus.page          = (page_q == PAGE1);
  assign bus.frame_latched = frame_q;

endmodule
